// File: rtl/mod_dp.sv
// mod_dp -- datapath half of the modulo unit.
// Holds dividend/divisor and computes A mod B (and A div B) by repeated
// unsigned subtraction, one subtraction per clock while `subtract` is high.
//
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   load          latch A/B, clear quotient and flags, return to IDLE (wins over subtract)
//   subtract      level request: iterate until done, then hold the acknowledge
//   A, B          dividend / divisor (unsigned, WIDTH bits)
//   subtract_ack  high while the result is final and subtract is still high
//   remainder     working remainder; final value is A mod B (A when B == 0)
//   quotient      subtractions performed so far; final value is A div B
//   div_by_zero   set when the finished operation had B == 0
module mod_dp #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             subtract,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             subtract_ack,
   output logic [WIDTH-1:0] remainder,
   output logic [WIDTH-1:0] quotient,
   output logic             div_by_zero
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] div_r;
   logic [WIDTH-1:0] quo_r;
   logic             dbz_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         rem_r <= '0;
         div_r <= '0;
         quo_r <= '0;
         dbz_r <= 1'b0;
      end else if (load) begin
         state <= IDLE;
         rem_r <= A;
         div_r <= B;
         quo_r <= '0;
         dbz_r <= 1'b0;
      end else begin
         case (state)
            IDLE, RUN: begin
               if (subtract) begin
                  if (div_r == '0) begin
                     // Nothing to iterate; finish at once with remainder = A.
                     dbz_r <= 1'b1;
                     state <= ACK;
                  end else if (rem_r >= div_r) begin
                     // Guarded by the compare, so this never wraps.
                     rem_r <= rem_r - div_r;
                     quo_r <= quo_r + 1'b1;
                     state <= RUN;
                  end else begin
                     state <= ACK;
                  end
               end else begin
                  // Pause: working registers hold, so a later request resumes.
                  state <= IDLE;
               end
            end
            ACK: begin
               if (!subtract) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign subtract_ack = (state == ACK);
   assign remainder    = rem_r;
   assign quotient     = quo_r;
   assign div_by_zero  = dbz_r;

endmodule

// File: tb/tb_mod_dp.sv
module tb_mod_dp;

   localparam int W       = 32;
   localparam int MAX_EDG = 1000;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         load = 1'b0;
   logic         subtract = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         subtract_ack;
   logic [W-1:0] remainder;
   logic [W-1:0] quotient;
   logic         div_by_zero;

   mod_dp #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .load(load), .subtract(subtract),
      .A(A), .B(B), .subtract_ack(subtract_ack), .remainder(remainder),
      .quotient(quotient), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] rem;
      logic [W-1:0] quo;
      logic         dbz;
      int           lat;   // edges from first subtract sample to ack visible
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load A/B, hold subtract until ack (optionally pausing 3 cycles after
   // pause_at edges), then compare against the scoreboard entry.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int pause_at, input bit keep_sub);
      exp_t e;
      exp_t got;
      int   edges;
      bit   acked;
      logic [W-1:0] q0;
      A = a; B = b; load = 1'b1; subtract = 1'b0;
      tick();
      load = 1'b0;
      chk({tag, "_loaded_rem"}, remainder, a);
      chk({tag, "_loaded_quo"}, quotient, '0);
      e.rem = (b == 0) ? a : a % b;
      e.quo = (b == 0) ? '0 : a / b;
      e.dbz = (b == 0);
      e.lat = (b == 0) ? 1 : int'(a / b) + 1;
      sb.push_back(e);
      subtract = 1'b1;
      edges = 0;
      acked = 0;
      while (!acked && edges < MAX_EDG) begin
         if (pause_at > 0 && edges == pause_at) begin
            q0 = quotient;
            subtract = 1'b0;
            repeat (3) begin
               tick();
               chk({tag, "_pause_ack"}, {31'd0, subtract_ack}, '0);
            end
            chk({tag, "_pause_quo"}, quotient, q0);
            subtract = 1'b1;
         end
         tick();
         edges++;
         if (subtract_ack) acked = 1;
      end
      got = sb.pop_front();
      chk({tag, "_acked"}, {31'd0, acked}, 32'd1);
      chk({tag, "_rem"}, remainder, got.rem);
      chk({tag, "_quo"}, quotient, got.quo);
      chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, got.dbz});
      if (pause_at == 0) chk({tag, "_lat"}, edges, got.lat);
      if (!keep_sub) begin
         tick();
         chk({tag, "_ack_hold"}, {31'd0, subtract_ack}, 32'd1);
         subtract = 1'b0;
         tick();
         chk({tag, "_ack_drop"}, {31'd0, subtract_ack}, '0);
         chk({tag, "_rem_stable"}, remainder, got.rem);
         chk({tag, "_quo_stable"}, quotient, got.quo);
      end
   endtask

   initial begin
      #12;
      chk("rst_rem", remainder, '0);
      chk("rst_quo", quotient, '0);
      chk("rst_ack", {31'd0, subtract_ack}, '0);
      chk("rst_dbz", {31'd0, div_by_zero}, '0);
      reset = 1'b0;
      tick();

      // Reset mid-run.
      A = 32'd100; B = 32'd3; load = 1'b1;
      tick();
      load = 1'b0; subtract = 1'b1;
      repeat (5) tick();
      chk("midrun_progress", quotient, 32'd5);
      reset = 1'b1;
      #2;
      subtract = 1'b0;
      chk("midrst_rem", remainder, '0);
      chk("midrst_quo", quotient, '0);
      chk("midrst_ack", {31'd0, subtract_ack}, '0);
      chk("midrst_dbz", {31'd0, div_by_zero}, '0);
      tick();
      reset = 1'b0;
      tick();
      chk("postrst_ack", {31'd0, subtract_ack}, '0);

      run_op("a17b5", 32'd17, 32'd5, 0, 0);
      run_op("a4b9",  32'd4,  32'd9, 0, 0);
      run_op("a9b9",  32'd9,  32'd9, 0, 0);
      run_op("a42b0", 32'd42, 32'd0, 0, 0);
      run_op("a0b7",  32'd0,  32'd7, 0, 0);
      run_op("a50b7p", 32'd50, 32'd7, 3, 0);
      for (int i = 0; i < 4; i++)
         run_op("rnd", W'($urandom_range(0, 500)), W'($urandom_range(1, 20)), 0, 0);

      // Controller-style sequence with subtract left high at ack, then a
      // load during ACK must clear the acknowledge on the next cycle.
      run_op("big", 32'hFFFF_FFFF, 32'h1000_0000, 0, 1);
      A = 32'd77; B = 32'd8; load = 1'b1;
      tick();
      load = 1'b0;
      chk("ldack_ack", {31'd0, subtract_ack}, '0);
      chk("ldack_rem", remainder, 32'd77);
      chk("ldack_quo", quotient, '0);
      chk("ldack_dbz", {31'd0, div_by_zero}, '0);
      subtract = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
